ifu_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the core's next-PC logic and the instruction-memory request/response bus.
- Holds the architectural fetch PC.
- Issues one fetch request at a time and captures the response into an output register.
- Hands the instruction to decode over a valid/ready handshake.
- On a redirect from execute (branch/jal/jalr target), kills any in-flight or buffered fetch.

---
 rtl/ifu_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, a single-entry decode buffer, redirect kill.
// Optional performance counters are compiled in with `define IFU_PERF_CNT_EN.
module ifu_fetch_ctrl #(
   parameter int             DW       = 64,
   parameter int             IW       = 32,
   parameter logic [DW-1:0]  RESET_PC = DW'(64'h8000_0000)
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           fetch_en,
   input  logic           redir_valid,
   input  logic [DW-1:0]  redir_pc,
   output logic           req_valid,
   input  logic           req_ready,
   output logic [DW-1:0]  req_addr,
   input  logic           rsp_valid,
   input  logic [IW-1:0]  rsp_data,
   input  logic           rsp_err,
   output logic           inst_valid,
   input  logic           inst_ready,
   output logic [IW-1:0]  inst,
   output logic [DW-1:0]  inst_pc,
`ifdef IFU_PERF_CNT_EN
   output logic [63:0]    perf_fetch_cnt,
   output logic [63:0]    perf_kill_cnt,
`endif
   output logic           inst_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]    state, state_nxt;
   logic [DW-1:0] fetch_pc, pc_nxt;
   logic          kill, kill_nxt;
   logic          capture, release_buf, discard_rsp;

   assign req_valid = (state == S_REQ);
   assign req_addr  = fetch_pc;

   always_comb begin
      state_nxt   = state;
      kill_nxt    = kill;
      pc_nxt      = fetch_pc;
      capture     = 1'b0;
      release_buf = 1'b0;
      discard_rsp = 1'b0;
      case (state)
         S_IDLE: if (fetch_en) state_nxt = S_REQ;
         S_REQ: begin
            if (req_ready) begin
               state_nxt = S_WAIT;
               kill_nxt  = redir_valid;
            end
         end
         S_WAIT: begin
            if (rsp_valid) begin
               // A redirect in the response cycle kills it directly, so kill never needs setting here.
               if (kill || redir_valid) begin
                  discard_rsp = 1'b1;
                  kill_nxt    = 1'b0;
                  state_nxt   = fetch_en ? S_REQ : S_IDLE;
               end else begin
                  capture   = 1'b1;
                  state_nxt = S_HOLD;
               end
            end else if (redir_valid) begin
               kill_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redir_valid || inst_ready) begin
               release_buf = 1'b1;
               state_nxt   = fetch_en ? S_REQ : S_IDLE;
               if (!redir_valid) pc_nxt = fetch_pc + DW'(4);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (redir_valid) pc_nxt = {redir_pc[DW-1:1], 1'b0};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         fetch_pc   <= RESET_PC;
         kill       <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
         inst_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= pc_nxt;
         kill     <= kill_nxt;
         if (capture) begin
            inst_valid <= 1'b1;
            inst       <= rsp_data;
            inst_pc    <= fetch_pc;
            inst_err   <= rsp_err;
         end else if (release_buf) begin
            inst_valid <= 1'b0;
         end
      end
   end

`ifdef IFU_PERF_CNT_EN
   function automatic logic [63:0] sat_inc(input logic [63:0] v);
      return (&v) ? v : v + 64'd1;
   endfunction

   logic kill_evt;
   // A buffer consumed by decode in the redirect cycle was delivered, not discarded.
   assign kill_evt = discard_rsp || (state == S_HOLD && redir_valid && !inst_ready);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_fetch_cnt <= '0;
         perf_kill_cnt  <= '0;
      end else begin
         if (inst_valid && inst_ready) perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
         if (kill_evt)                 perf_kill_cnt  <= sat_inc(perf_kill_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl against a transaction-level fetch model and a latency-randomizing imem.
module tb_ifu_fetch_ctrl;

   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic        fetch_en, redir_valid, req_ready, rsp_valid, rsp_err, inst_ready;
   logic [63:0] redir_pc;
   logic [31:0] rsp_data;
   logic        req_valid, inst_valid, inst_err;
   logic [63:0] req_addr, inst_pc;
   logic [31:0] inst;
`ifdef IFU_PERF_CNT_EN
   logic [63:0] perf_fetch_cnt, perf_kill_cnt;
`endif

   ifu_fetch_ctrl dut (
      .clk(clk), .rstn(rstn), .fetch_en(fetch_en),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc),
`ifdef IFU_PERF_CNT_EN
      .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt),
`endif
      .inst_err(inst_err)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: architectural PC, a pending request flag, one outstanding
   // transaction (with a kill mark) and at most one instruction awaiting decode.
   logic [63:0] m_pc, m_addr, h_pc;
   logic        m_req, m_outst, m_kill, m_held, h_err;
   logic [31:0] h_data;
   logic [63:0] delivered[$];

   // Memory side: one response per accepted request after 1..kmax cycles.
   bit          mem_busy;
   int          mem_cnt;

   // Stimulus knobs (percent probabilities)
   int p_fen, p_rdy, p_irdy, p_redir, kmax;
   bit fixed_data;

   task automatic model_reset();
      m_pc = RST_PC; m_req = 0; m_outst = 0; m_kill = 0; m_held = 0;
      m_addr = '0; h_pc = '0; h_err = 0; h_data = '0;
      mem_busy = 0; mem_cnt = 0;
   endtask

   task automatic check_outputs();
      chk("req_valid", 64'(req_valid), 64'(m_req));
      chk("req_addr", req_addr, m_pc);
      chk("inst_valid", 64'(inst_valid), 64'(m_held));
      if (m_held) begin
         chk("inst", 64'(inst), 64'(h_data));
         chk("inst_pc", inst_pc, h_pc);
         chk("inst_err", 64'(inst_err), 64'(h_err));
      end
   endtask

   // Called at a negedge: check, drive, predict the coming posedge, advance.
   task automatic step();
      bit free;
      logic [63:0] n_pc;
      bit n_req, n_outst, n_kill, n_held;
      check_outputs();
      fetch_en    = ($urandom_range(99, 0) < p_fen);
      req_ready   = ($urandom_range(99, 0) < p_rdy);
      inst_ready  = ($urandom_range(99, 0) < p_irdy);
      redir_valid = ($urandom_range(99, 0) < p_redir);
      case ($urandom_range(3, 0))
         0:       redir_pc = 64'hFFFF_FFFF_FFFF_FFFD;
         default: redir_pc = RST_PC + 64'($urandom_range(4095, 0));
      endcase
      rsp_valid = mem_busy && (mem_cnt == 0);
      rsp_data  = fixed_data ? 32'h0000_0013 : $urandom;
      rsp_err   = fixed_data ? 1'b0 : ($urandom_range(7, 0) == 0);

      n_pc = m_pc; n_req = m_req; n_outst = m_outst; n_kill = m_kill; n_held = m_held;
      free = 0;
      if (m_req && req_ready) begin
         n_req = 0; n_outst = 1; n_kill = redir_valid; m_addr = m_pc;
      end else if (!m_req && !m_outst && !m_held) begin
         n_req = fetch_en;
      end
      if (m_outst && rsp_valid) begin
         n_outst = 0;
         if (m_kill || redir_valid) begin
            n_kill = 0; free = 1;
         end else begin
            n_held = 1; h_data = rsp_data; h_pc = m_addr; h_err = rsp_err;
         end
      end else if (m_outst && redir_valid) begin
         n_kill = 1;
      end
      if (m_held && (redir_valid || inst_ready)) begin
         n_held = 0; free = 1;
         if (inst_ready) delivered.push_back(h_pc);
         if (!redir_valid) n_pc = m_pc + 64'd4;
      end
      if (redir_valid) n_pc = {redir_pc[63:1], 1'b0};
      if (free) n_req = fetch_en;

      if (rsp_valid) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (req_valid && req_ready) begin
         mem_busy = 1; mem_cnt = $urandom_range(kmax, 1) - 1;
      end

      @(posedge clk);
      m_pc = n_pc; m_req = n_req; m_outst = n_outst; m_kill = n_kill; m_held = n_held;
      @(negedge clk);
   endtask

   task automatic phase(input int cycles, input int fen, input int rdy, input int irdy,
                        input int rdr, input int km, input bit fixd);
      p_fen = fen; p_rdy = rdy; p_irdy = irdy; p_redir = rdr; kmax = km; fixed_data = fixd;
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
      chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
      chk({tag, "_inst"}, 64'(inst), 64'd0);
      chk({tag, "_inst_pc"}, inst_pc, 64'd0);
      chk({tag, "_inst_err"}, 64'(inst_err), 64'd0);
      chk({tag, "_req_addr"}, req_addr, RST_PC);
`ifdef IFU_PERF_CNT_EN
      chk({tag, "_perf_fetch"}, perf_fetch_cnt, 64'd0);
      chk({tag, "_perf_kill"}, perf_kill_cnt, 64'd0);
`endif
   endtask

   initial begin
      int waited;
      fetch_en = 0; redir_valid = 0; redir_pc = '0; req_ready = 0;
      rsp_valid = 0; rsp_data = '0; rsp_err = 0; inst_ready = 0;
      rstn = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_checks("rst");
      rstn = 1'b1;

      // Straight-line fetch, 1-cycle memory, always-ready decode
      phase(20, 100, 100, 100, 0, 1, 1'b1);
      chk("seq_len_ge3", 64'(delivered.size() >= 3), 64'd1);
      if (delivered.size() >= 3) begin
         chk("seq_pc0", delivered[0], 64'h8000_0000);
         chk("seq_pc1", delivered[1], 64'h8000_0004);
         chk("seq_pc2", delivered[2], 64'h8000_0008);
      end

      phase(300, 70, 40, 40, 0, 5, 1'b0);   // backpressure on both sides
      phase(500, 90, 70, 70, 15, 4, 1'b0);  // redirect-heavy
      phase(300, 25, 60, 50, 5, 6, 1'b0);   // fetch_en toggling, draining to idle
      phase(200, 100, 80, 10, 0, 3, 1'b0);  // decode stalls

      // Asynchronous reset while an instruction is held
      p_irdy = 0; p_redir = 0;
      waited = 0;
      while (!m_held && waited < 200) begin
         step();
         waited++;
      end
      chk("hold_reached", 64'(m_held), 64'd1);
      #2 rstn = 1'b0;
      #1 reset_checks("async_rst");
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      delivered.delete();
      phase(10, 100, 100, 100, 0, 1, 1'b1);
      chk("post_rst_first_pc", (delivered.size() > 0) ? delivered[0] : 64'hDEAD, RST_PC);

      phase(3000, 80, 60, 60, 8, 5, 1'b0);  // mixed soak

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
